// File: rtl/alu_result_tx.sv
// rtl/alu_result_tx.sv - splits a 16-bit ALU result into two bytes for a UART transmitter
// Bytes are handed over with a valid/busy handshake; results arriving mid-transfer are dropped.
module alu_result_tx #(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] ALU_OUT,
   input  logic        OUT_VALID,
   input  logic        TX_BUSY,
   output logic [7:0]  TX_P_DATA,
   output logic        TX_D_VLD,
   output logic        RES_BUSY,
   output logic        TX_DONE,
   output logic        OVERRUN
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SEND_B0 = 3'd1,
      WAIT_B0 = 3'd2,
      SEND_B1 = 3'd3,
      WAIT_B1 = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] hold_q, hold_d;
   logic [7:0]  tx_p_data_q, tx_p_data_d;
   logic        tx_d_vld_q, tx_d_vld_d;
   logic        res_busy_q, res_busy_d;
   logic        tx_done_q, tx_done_d;
   logic        overrun_q, overrun_d;
   logic [7:0]  byte0, byte1;

   assign byte0 = LSB_FIRST ? hold_q[7:0]  : hold_q[15:8];
   assign byte1 = LSB_FIRST ? hold_q[15:8] : hold_q[7:0];

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      tx_p_data_d = tx_p_data_q;
      tx_d_vld_d  = 1'b0;
      tx_done_d   = 1'b0;
      // Any result offered while a word is in flight is lost, including on the returning edge.
      overrun_d   = overrun_q | (OUT_VALID && (state_q != IDLE));
      case (state_q)
         IDLE: begin
            if (OUT_VALID) begin
               hold_d  = ALU_OUT;
               state_d = SEND_B0;
            end
         end
         SEND_B0: begin
            if (!TX_BUSY) begin
               tx_p_data_d = byte0;
               tx_d_vld_d  = 1'b1;
               state_d     = WAIT_B0;
            end
         end
         WAIT_B0: begin
            tx_d_vld_d = 1'b1;
            if (TX_BUSY) begin
               tx_d_vld_d = 1'b0;
               state_d    = SEND_B1;
            end
         end
         SEND_B1: begin
            if (!TX_BUSY) begin
               tx_p_data_d = byte1;
               tx_d_vld_d  = 1'b1;
               state_d     = WAIT_B1;
            end
         end
         WAIT_B1: begin
            tx_d_vld_d = 1'b1;
            if (TX_BUSY) begin
               tx_d_vld_d = 1'b0;
               tx_done_d  = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      res_busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         hold_q      <= 16'h0000;
         tx_p_data_q <= 8'h00;
         tx_d_vld_q  <= 1'b0;
         res_busy_q  <= 1'b0;
         tx_done_q   <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         tx_p_data_q <= tx_p_data_d;
         tx_d_vld_q  <= tx_d_vld_d;
         res_busy_q  <= res_busy_d;
         tx_done_q   <= tx_done_d;
         overrun_q   <= overrun_d;
      end
   end

   assign TX_P_DATA = tx_p_data_q;
   assign TX_D_VLD  = tx_d_vld_q;
   assign RES_BUSY  = res_busy_q;
   assign TX_DONE   = tx_done_q;
   assign OVERRUN   = overrun_q;

endmodule
